// File: rtl/chronos_i2c_pkg.sv
// Shared definitions for the Chronos I2C register-bank target:
// FSM state encoding and default build-time constants.
`timescale 1ns/1ps

package chronos_i2c_pkg;

  // Default 7-bit bus address of the register bank target.
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h3C;

  // Default number of consecutive equal samples before a filtered line moves.
  localparam int FILTER_LEN_DEFAULT = 3;

  // Protocol states of the target.
  typedef enum logic [3:0] {
    IDLE,
    DEV,
    ACK_DEV,
    PTR,
    WR,
    ACK_W,
    RD,
    MACK,
    WAIT_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_input_filter.sv
// Conditions one asynchronous bus pin: a two-flop synchroniser followed by
// a glitch filter that only moves its output after FILTER_LEN consecutive
// synchronised samples disagree with the current output level.
`timescale 1ns/1ps

module i2c_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Bring the pin into the clk domain; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], pin};
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      level <= sync[1];
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target front end for the Chronos register bank. Decodes the bus,
// keeps an auto-incrementing register pointer and drives single-cycle
// read/write strobes into the byte-wide bank. No clock stretching.
`timescale 1ns/1ps

module i2c_reg_target
  import chronos_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEV_ADDR_DEFAULT,
  parameter int         FILTER_LEN = FILTER_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic       wr_en,
  output logic       rd_en,
  output logic       busy
);

  logic       scl_f;
  logic       sda_f;
  logic       scl_q;
  logic       sda_q;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;

  i2c_state_t state;
  logic [3:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift;
  logic [7:0] ptr;
  logic       rw_bit;
  logic       ack_phase;
  logic [1:0] rd_pipe;

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (scl_i),
    .level (scl_f)
  );

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sda_i),
    .level (sda_f)
  );

  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign start_cond = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_cond  = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte    = {rx_shift, sda_f};
  assign addr       = ptr;

  // Previous filtered levels for edge and START/STOP detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // Bank reads are registered, so rdata is captured two clocks after rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= 2'b00;
    end else begin
      rd_pipe <= {rd_pipe[0], rd_en};
    end
  end

  // Protocol FSM: bit shifting, ACK driving, pointer and bank strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 8'd0;
      ptr       <= 8'd0;
      wdata     <= 8'd0;
      rw_bit    <= 1'b0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      if (wr_en) begin
        ptr <= ptr + 8'd1;
      end
      if (rd_pipe[1]) begin
        tx_shift <= rdata;
      end

      if (stop_cond) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
      end else if (start_cond) begin
        state     <= DEV;
        sda_oe    <= 1'b0;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end

          DEV: begin
            if (scl_rise) begin
              rx_shift <= rx_byte[6:0];
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy   <= 1'b1;
                  rw_bit <= rx_byte[0];
                  rd_en  <= rx_byte[0];
                  state  <= ACK_DEV;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ACK_DEV: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                if (rw_bit) begin
                  sda_oe   <= ~tx_shift[7];
                  tx_shift <= {tx_shift[6:0], 1'b0};
                  bit_cnt  <= 4'd1;
                  state    <= RD;
                end else begin
                  sda_oe  <= 1'b0;
                  bit_cnt <= 4'd0;
                  state   <= PTR;
                end
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              rx_shift <= rx_byte[6:0];
              if (bit_cnt == 4'd7) begin
                ptr     <= rx_byte;
                bit_cnt <= 4'd0;
                state   <= ACK_W;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          WR: begin
            if (scl_rise) begin
              rx_shift <= rx_byte[6:0];
              if (bit_cnt == 4'd7) begin
                wdata   <= rx_byte;
                wr_en   <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= ACK_W;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ACK_W: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= 4'd0;
                state     <= WR;
              end
            end
          end

          RD: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= MACK;
              end else begin
                sda_oe   <= ~tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end

          MACK: begin
            if (scl_rise) begin
              ptr <= ptr + 8'd1;
              if (!sda_f) begin
                rd_en <= 1'b1;
                state <= RD;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
I2C target (slave) front end for the Chronos register bank. It decodes the host's I2C bus and acts as the initiator on the byte-wide register interface, driving addr/wdata/wr_en/rd_en and consuming the registered rdata. It sits between the board I2C pins and the configuration register bank. It supports a register-pointer write, burst writes and burst/random reads with auto-increment; there is no clock stretching.

Parameters:
DEV_ADDR, 7'h3C, 7-bit I2C target address.
FILTER_LEN, 3, consecutive identical clk samples required before a filtered SCL/SDA level changes (range 1-8).

Ports:
clk  in  1  system clock (200 MHz)
rst_n  in  1  reset, asynchronous, active-low
scl_i  in  1  raw SCL pin level (asynchronous)
sda_i  in  1  raw SDA pin level (asynchronous)
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
addr  out  8  register pointer presented to the bank
wdata  out  8  write data, registered
rdata  in  8  read data from the bank, valid 1 clk after rd_en
wr_en  out  1  one-clk write strobe
rd_en  out  1  one-clk read strobe
busy  out  1  1 from a matched START until STOP

Behaviour:
- Reset: sda_oe=0, wr_en=0, rd_en=0, wdata=0, addr(ptr)=0, busy=0, state IDLE. Reset mid-transfer releases SDA immediately.
- Input conditioning: 2-FF sync, then FILTER_LEN glitch filter on SCL and SDA (equal latency). Filtered edges: scl_rise, scl_fall. START = SDA 1->0 while SCL=1. STOP = SDA 0->1 while SCL=1.
- Bits are sampled on scl_rise, MSB first. The target changes SDA only on scl_fall.
- START/repeated START in any state: abort the byte, clear the bit counter, sda_oe=0, go to DEV. STOP in any state: go to IDLE, sda_oe=0, busy=0. No strobe is issued for a partial byte.
- States:
  - IDLE: wait for START.
  - DEV: shift 8 bits. On the 8th scl_rise: if addr[7:1]==DEV_ADDR then busy=1 and go to ACK_DEV (if R/W=1, pulse rd_en at ptr this clk). Otherwise go to WAIT_STOP (never ACK).
  - ACK_DEV: sda_oe=1 from the next scl_fall through the following scl_fall. Then go to PTR if W; if R, load the shift register and go to RD.
  - PTR: the 8th bit loads ptr; go to ACK_W (no wr_en).
  - WR: on the 8th scl_rise, wdata<=byte and pulse wr_en with addr=ptr in the same clk; ptr increments the next clk. Go to ACK_W.
  - ACK_W: ACK as above, then go to WR.
  - RD: sda_oe = ~shift[7] on each scl_fall; 8 bits. Release SDA on the scl_fall after bit 0, then go to MACK.
  - MACK: sample the master's bit on scl_rise and increment ptr. If ACK (SDA=0), pulse rd_en at the new ptr the following clk and go to RD. If NACK, go to WAIT_STOP.
  - WAIT_STOP: SDA released; only START/STOP are honoured.
- rdata capture: latch into the shift register exactly 2 clks after rd_en (registered bank read plus 1). This must complete before the next scl_fall, which holds for SCL ≤ 1 MHz.
- Pointer: 8-bit and wraps 0xFF->0x00. It persists across transactions, so a read without a pointer write continues from the last ptr.
- wr_en and rd_en are never high in the same clk.

Decomposition:
- Package chronos_i2c_pkg holds:
  - state enum i2c_state_t {IDLE, DEV, ACK_DEV, PTR, WR, ACK_W, RD, MACK, WAIT_STOP};
  - default DEV_ADDR constant;
  - FILTER_LEN default.
- Sub-module i2c_input_filter (sync plus N-sample filter, 1-bit) is instantiated for SCL and SDA.

Test Plan:
- Reset mid-byte (assert rst_n low while sda_oe=1) -> sda_oe=0 within 0 clks (async); wr_en=rd_en=0; addr=0x00.
- START, 0x78, 0x01, 0x3C, STOP -> three ACKs; exactly one wr_en with addr=0x01, wdata=0x3C.
- START, 0x78, 0xFF, 0xAA, 0x55, STOP -> wr_en at addr 0xFF/0xAA, then addr 0x00/0x55; final ptr 0x01.
- START, 0x78, 0xFE, Sr, 0x79, read with ACK then NACK, STOP; bank model 0xFE=0x05, 0xFF=0xC4 -> SDA bytes 0x05 then 0xC4; rd_en at 0xFE and 0xFF only; final ptr 0x00.
- START, 0x7A (wrong address), data bytes, STOP -> sda_oe never asserted, no strobes; the next valid write to 0x78 succeeds.
- 1-clk SCL glitch with FILTER_LEN=3 -> no bit shifted. STOP after 5 data bits of a WR byte -> no wr_en; state IDLE.
